// File: rtl/alu32_pkg.sv
// Shared opcode encoding and flag bit positions for the alu32_en datapath ALU.
package alu32_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_INC  = 3'd2,
    OP_DEC  = 3'd3,
    OP_PASS = 3'd4,
    OP_NOT  = 3'd5,
    OP_OR   = 3'd6,
    OP_AND  = 3'd7
  } alu_op_e;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

endpackage

// File: rtl/alu32_en_if.sv
// Operand/result bundle between the operand registers and the ALU.
// The flags signal exists only when ALU_FLAGS_EN is defined.
interface alu32_en_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       opcode;
  logic             enable;
  logic [WIDTH-1:0] result;
  logic             valid;
`ifdef ALU_FLAGS_EN
  logic [3:0]       flags;
`endif

  modport master (
    output A, B, opcode, enable,
`ifdef ALU_FLAGS_EN
    input  flags,
`endif
    input  result, valid
  );

  modport slave (
    input  A, B, opcode, enable,
`ifdef ALU_FLAGS_EN
    output flags,
`endif
    output result, valid
  );
endinterface

// File: rtl/alu32_core.sv
// Combinational ALU datapath: one shared adder/subtractor serves add/sub/inc/dec.
// Carry and overflow outputs exist only when ALU_FLAGS_EN is defined.
module alu32_core
  import alu32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [2:0]       opcode_i,
`ifdef ALU_FLAGS_EN
  output logic             carry_o,
  output logic             overflow_o,
`endif
  output logic [WIDTH-1:0] r_o
);

  alu_op_e          op;
  logic [WIDTH-1:0] y;
  logic             sub;
  logic             is_arith;

  assign op = alu_op_e'(opcode_i);

  // Second adder operand is forced to 0 for logic ops so unary ops never see B.
  always_comb begin
    y        = '0;
    sub      = 1'b0;
    is_arith = 1'b1;
    unique case (op)
      OP_ADD: y = b_i;
      OP_SUB: begin y = b_i; sub = 1'b1; end
      OP_INC: y = WIDTH'(1);
      OP_DEC: begin y = WIDTH'(1); sub = 1'b1; end
      default: is_arith = 1'b0;
    endcase
  end

`ifdef ALU_FLAGS_EN
  logic [WIDTH:0] arith;
  assign arith = sub ? ({1'b0, a_i} - {1'b0, y}) : ({1'b0, a_i} + {1'b0, y});

  // Bit WIDTH is carry-out for add and borrow (a < y) for subtract.
  always_comb begin
    carry_o    = is_arith & arith[WIDTH];
    overflow_o = 1'b0;
    if (is_arith) begin
      if (sub)
        overflow_o = (a_i[WIDTH-1] != y[WIDTH-1]) && (arith[WIDTH-1] != a_i[WIDTH-1]);
      else
        overflow_o = (a_i[WIDTH-1] == y[WIDTH-1]) && (arith[WIDTH-1] != a_i[WIDTH-1]);
    end
  end
`else
  logic [WIDTH-1:0] arith;
  assign arith = sub ? (a_i - y) : (a_i + y);
`endif

  always_comb begin
    r_o = arith[WIDTH-1:0];
    if (!is_arith) begin
      unique case (op)
        OP_PASS: r_o = a_i;
        OP_NOT:  r_o = ~a_i;
        OP_OR:   r_o = a_i | b_i;
        OP_AND:  r_o = a_i & b_i;
        default: r_o = arith[WIDTH-1:0];
      endcase
    end
  end

endmodule

// File: rtl/alu32_en.sv
// Registered ALU with operation enable; a disabled or reset ALU drives zero.
// Optional registered status flags {N,Z,C,V} are built when ALU_FLAGS_EN is defined.
module alu32_en
  import alu32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  alu32_en_if.slave  bus
);

  logic [WIDTH-1:0] r_comb;
  logic [WIDTH-1:0] result_q, result_d;
  logic             valid_q, valid_d;

`ifdef ALU_FLAGS_EN
  logic       carry, overflow;
  logic [3:0] flags_q, flags_d;
`endif

  alu32_core #(.WIDTH(WIDTH)) u_core (
    .a_i        (bus.A),
    .b_i        (bus.B),
    .opcode_i   (bus.opcode),
`ifdef ALU_FLAGS_EN
    .carry_o    (carry),
    .overflow_o (overflow),
`endif
    .r_o        (r_comb)
  );

  always_comb begin
    result_d = '0;
    valid_d  = 1'b0;
`ifdef ALU_FLAGS_EN
    flags_d  = '0;
`endif
    if (bus.enable) begin
      result_d = r_comb;
      valid_d  = 1'b1;
`ifdef ALU_FLAGS_EN
      flags_d[FLAG_N] = r_comb[WIDTH-1];
      flags_d[FLAG_Z] = (r_comb == '0);
      flags_d[FLAG_C] = carry;
      flags_d[FLAG_V] = overflow;
`endif
    end
  end

  // Reset wins over enable: an op captured on a reset edge is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      valid_q  <= 1'b0;
`ifdef ALU_FLAGS_EN
      flags_q  <= '0;
`endif
    end else begin
      result_q <= result_d;
      valid_q  <= valid_d;
`ifdef ALU_FLAGS_EN
      flags_q  <= flags_d;
`endif
    end
  end

  assign bus.result = result_q;
  assign bus.valid  = valid_q;
`ifdef ALU_FLAGS_EN
  assign bus.flags  = flags_q;
`endif

endmodule

// File: tb/tb_alu32_en.sv
// Self-checking bench for alu32_en: expected outputs are queued at issue time
// and popped one cycle later when the registered result is sampled.
module tb_alu32_en;
  import alu32_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu32_en_if #(.WIDTH(32)) bus ();

  alu32_en #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] res;
    logic        vld;
    logic [3:0]  flg;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  exp_t last_exp;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input bit r, input bit e, input logic [2:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
    exp_t x;
    logic [32:0] w;
    logic c, v;
    x.res = '0; x.vld = 1'b0; x.flg = '0;
    c = 1'b0; v = 1'b0; w = '0;
    if (r || !e) return x;
    case (op)
      3'd0: begin w = {1'b0, a} + {1'b0, b}; c = w[32]; v = (a[31] == b[31]) && (w[31] != a[31]); end
      3'd1: begin w = {1'b0, a - b}; c = (a < b); v = (a[31] != b[31]) && (w[31] != a[31]); end
      3'd2: begin w = {1'b0, a + 32'd1}; c = (a == 32'hFFFF_FFFF); v = (a == 32'h7FFF_FFFF); end
      3'd3: begin w = {1'b0, a - 32'd1}; c = (a == 32'd0); v = (a == 32'h8000_0000); end
      3'd4: w = {1'b0, a};
      3'd5: w = {1'b0, ~a};
      3'd6: w = {1'b0, a | b};
      default: w = {1'b0, a & b};
    endcase
    x.res = w[31:0];
    x.vld = 1'b1;
    x.flg = {w[31], (w[31:0] == 32'd0), c, v};
    return x;
  endfunction

  // Drive one operation, then sample the registered outputs #1 after the edge.
  task automatic issue(input string tag, input bit r, input bit e, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b,
                       input bit use_tab, input logic [31:0] tab_res);
    exp_t x;
    rst        = r;
    bus.enable = e;
    bus.opcode = op;
    bus.A      = a;
    bus.B      = b;
    x = model(r, e, op, a, b);
    if (use_tab) x.res = tab_res;
    sb_q.push_back(x);
    @(posedge clk);
    #1;
    x = sb_q.pop_front();
    last_exp = x;
    check_eq({tag, "_res"}, bus.result, x.res);
    check_eq({tag, "_vld"}, {31'd0, bus.valid}, {31'd0, x.vld});
`ifdef ALU_FLAGS_EN
    check_eq({tag, "_flg"}, {28'd0, bus.flags}, {28'd0, x.flg});
`endif
    $display("op=%0d en=%0b rst=%0b A=%08h B=%08h -> result=%08h valid=%0b",
             op, e, r, a, b, bus.result, bus.valid);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] tab [8];
  logic [31:0] ra, rb;

  initial begin
    tab[0] = 32'h0000_0008; tab[1] = 32'h0000_0002; tab[2] = 32'h0000_0006; tab[3] = 32'h0000_0004;
    tab[4] = 32'h0000_0005; tab[5] = 32'hFFFF_FFFA; tab[6] = 32'h0000_0007; tab[7] = 32'h0000_0001;
    rst = 1'b1; bus.enable = 1'b0; bus.opcode = '0; bus.A = '0; bus.B = '0;

    issue("reset", 1, 0, 3'd0, 32'd0, 32'd0, 1'b1, 32'd0);

    // Opcode sweep against literal results for A=5, B=3.
    for (int i = 0; i < 8; i++)
      issue($sformatf("sweep%0d", i), 0, 1, 3'(i), 32'd5, 32'd3, 1'b1, tab[i]);

    // Disabled ALU drives zero, then re-enable.
    issue("disabled", 0, 0, 3'd0, 32'd5, 32'd3, 1'b1, 32'd0);
    issue("reenable", 0, 1, 3'd0, 32'd5, 32'd3, 1'b1, 32'd8);

    // Inputs changing between edges must not disturb the registered result.
    bus.A = 32'hDEAD_BEEF; bus.opcode = 3'd5;
    #3;
    check_eq("hold_res", bus.result, last_exp.res);

    issue("inc_wrap", 0, 1, 3'd2, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 32'd0);
`ifdef ALU_FLAGS_EN
    check_eq("inc_wrap_Z", {31'd0, bus.flags[FLAG_Z]}, 32'd1);
    check_eq("inc_wrap_C", {31'd0, bus.flags[FLAG_C]}, 32'd1);
`endif
    issue("dec_wrap", 0, 1, 3'd3, 32'd0, 32'hAAAA_5555, 1'b1, 32'hFFFF_FFFF);
`ifdef ALU_FLAGS_EN
    check_eq("dec_wrap_N", {31'd0, bus.flags[FLAG_N]}, 32'd1);
    check_eq("dec_wrap_C", {31'd0, bus.flags[FLAG_C]}, 32'd1);
`endif
    issue("add_ovf", 0, 1, 3'd0, 32'h7FFF_FFFF, 32'd1, 1'b1, 32'h8000_0000);
`ifdef ALU_FLAGS_EN
    check_eq("add_ovf_V", {31'd0, bus.flags[FLAG_V]}, 32'd1);
    check_eq("add_ovf_N", {31'd0, bus.flags[FLAG_N]}, 32'd1);
`endif
    issue("sub_borrow", 0, 1, 3'd1, 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE);
`ifdef ALU_FLAGS_EN
    check_eq("sub_borrow_C", {31'd0, bus.flags[FLAG_C]}, 32'd1);
    check_eq("sub_borrow_V", {31'd0, bus.flags[FLAG_V]}, 32'd0);
`endif

    // Reset on the same edge as an enabled op discards it.
    issue("rst_mid", 1, 1, 3'd0, 32'd5, 32'd3, 1'b1, 32'd0);
    issue("after_rst", 0, 1, 3'd0, 32'd5, 32'd3, 1'b1, 32'd8);

    // Back-to-back ops with random operands, one per cycle.
    for (int i = 0; i < 8; i++) begin
      ra = $urandom;
      rb = $urandom;
      issue($sformatf("pipe%0d", i), 0, 1, 3'(7 - i), ra, rb, 1'b0, 32'd0);
    end

    // Unary ops must ignore B entirely, including X.
    issue("not_xb", 0, 1, 3'd5, 32'h0F0F_1234, 32'hxxxx_xxxx, 1'b1, 32'hF0F0_EDCB);
    issue("inc_xb", 0, 1, 3'd2, 32'h0000_00FF, 32'hxxxx_xxxx, 1'b1, 32'h0000_0100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu32_en.md
Name: alu32_en

Overview:
- Registered 32-bit, 8-operation ALU with an operation enable.
- Sits in the datapath between operand registers and the writeback mux.
- Combinational compute; the result and status are registered, so latency is 1 clock.
- When the enable is low, the result register is cleared to zero.

Parameters:
- WIDTH, 32, operand and result width in bits (must be >= 2).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous reset, active-high.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B; ignored by unary ops.
- opcode  input  3  operation select.
- enable  input  1  operation enable, sampled at the clock edge.
- result  output  WIDTH  registered result.
- valid  output  1  high for the cycle after an enabled operation was captured.
- flags  output  4  {negative, zero, carry, overflow}, registered (ALU_FLAGS_EN only).

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: on a rising edge with rst=1, result=0, valid=0, flags=0. rst has priority over enable.
- Opcodes (combinational value R):
  - 000: A+B
  - 001: A-B
  - 010: A+1
  - 011: A-1
  - 100: A (pass)
  - 101: ~A
  - 110: A|B
  - 111: A&B
- Arithmetic is modulo 2^WIDTH and wraps silently (e.g. FFFFFFFF+1=00000000, 0-1=FFFFFFFF).
- Edge with rst=0 and enable=1: result<=R, valid<=1.
- Edge with rst=0 and enable=0: result<=0, valid<=0 (disabled ALU drives zero).
- Latency: result and valid reflect the inputs sampled at the previous rising edge.
  - Inputs changing between edges have no effect on outputs.
- Back-to-back: a new operation may be issued every cycle; there is no stall or backpressure.
- Reset mid-operation: the operation captured at a reset edge is discarded; outputs are 0 on the following cycle.
- No X propagation from unused B: unary ops must not depend on B.

Optional Feature:
- Macro ALU_FLAGS_EN.
- Defined: flags port present, registered alongside result.
  - negative = R[WIDTH-1].
  - zero = (R==0).
  - carry:
    - add/inc: carry-out.
    - sub/dec: borrow, i.e. 1 when the minuend is unsigned-less-than the subtrahend.
    - all other ops: 0.
  - overflow:
    - signed two's-complement overflow for add/sub/inc/dec.
    - all other ops: 0.
  - When enable=0 or on reset, flags<=0.
- Undefined: no flags port and no flag logic; the rest of the behaviour is identical.

Decomposition:
- Package alu32_pkg holds:
  - opcode enum: OP_ADD, OP_SUB, OP_INC, OP_DEC, OP_PASS, OP_NOT, OP_OR, OP_AND = 0..7.
  - flag bit index constants: FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
- One natural sub-module: alu32_core.
  - Purely combinational: A, B, opcode -> R (plus carry/overflow under ALU_FLAGS_EN).
  - The top level holds only the output registers and the enable/reset logic.

Test Plan:
- Enable=1, A=5, B=3, sweep opcode 000..111. After each edge, result must be:
  - 000: 00000008
  - 001: 00000002
  - 010: 00000006
  - 011: 00000004
  - 100: 00000005
  - 101: FFFFFFFA
  - 110: 00000007
  - 111: 00000001
  - valid=1 throughout.
- Enable=0, A=5, B=3, op=000 -> result=00000000, valid=0 after the edge; re-enabling resumes the 1-cycle latency.
- Wrap cases:
  - op=010, A=FFFFFFFF -> result 00000000; flags Z=1, C=1.
  - op=011, A=0 -> result FFFFFFFF; flags N=1, C=1 (borrow).
- Signed overflow:
  - op=000, A=7FFFFFFF, B=1 -> result 80000000, V=1, N=1.
  - op=001, A=3, B=5 -> result FFFFFFFE, C=1, V=0.
- Reset: issue op=000, A=5, B=3 with rst=1 on the same edge -> result=0, valid=0. Deassert rst -> the next enabled op appears after 1 cycle.
- Pipelining: change opcode every cycle for 8 cycles -> each result matches the inputs of the previous cycle, with no bubbles.
